// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: state encoding, mac opcode fields and pipeline depth
// shared by the MAC job sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    OPS,
    SAT,
    DRAIN0,
    DRAIN1,
    CAPTURE,
    OUT
  } state_t;

  localparam logic [1:0] OP2_CLR = 2'b00;
  localparam logic [1:0] OP2_MUL = 2'b01;
  localparam logic [1:0] OP2_MAC = 2'b10;
  localparam logic [1:0] OP2_SAT = 2'b11;

  localparam int MAC_PIPE_DEPTH = 2;

  function automatic logic [2:0] opcode(
    input logic       mode,
    input logic [1:0] op2
  );
    return {mode, op2};
  endfunction

endpackage

// File: rtl/mac_seq.sv
// mac_seq: streams dot-product jobs into the mac and returns one result per job.
// Optional: define MAC_SEQ_OVF_FLAG_EN to add the registered res_ovf flag.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_sat,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_multiplier,
  input  logic [15:0]      op_multiplicand,
  output logic [2:0]       mac_instruction,
  output logic [15:0]      mac_multiplier,
  output logic [15:0]      mac_multiplicand,
  output logic             mac_stall,
  input  logic [7:0]       mac_protect,
  input  logic [31:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [7:0]       res_protect,
`ifdef MAC_SEQ_OVF_FLAG_EN
  output logic             res_ovf,
`endif
  output logic             busy
);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             sat_q, sat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q;
  logic [7:0]       prot_q;
  logic             issue;
  logic             capture;
  logic [1:0]       op2;
  state_t           tail_st;

  assign tail_st = sat_q ? SAT : DRAIN0;

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    sat_d            = sat_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    issue            = 1'b0;
    capture          = 1'b0;
    op2              = OP2_CLR;
    op_ready         = 1'b0;
    mac_multiplier   = '0;
    mac_multiplicand = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          sat_d   = cmd_sat;
          len_d   = cmd_len;
          cnt_d   = cmd_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        issue   = 1'b1;
        state_d = (len_q != '0) ? OPS : tail_st;
      end
      OPS: begin
        op_ready = 1'b1;
        if (op_valid) begin
          issue            = 1'b1;
          op2              = (cnt_q == len_q) ? OP2_MUL : OP2_MAC;
          mac_multiplier   = op_multiplier;
          mac_multiplicand = op_multiplicand;
          cnt_d            = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = tail_st;
        end
      end
      SAT: begin
        issue   = 1'b1;
        op2     = OP2_SAT;
        state_d = DRAIN0;
      end
      // CLR drains push the result out and leave the mac clean
      DRAIN0: begin
        issue   = 1'b1;
        state_d = DRAIN1;
      end
      DRAIN1: begin
        issue   = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      sat_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      prot_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        data_q <= mac_result;
        prot_q <= mac_protect;
      end
    end
  end

  assign mac_stall       = ~issue;
  assign mac_instruction = issue ? opcode(mode_q, op2) : 3'b000;
  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign res_valid       = (state_q == OUT);
  assign res_data        = data_q;
  assign res_protect     = prot_q;

`ifdef MAC_SEQ_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  always_comb begin
    if (mode_q) begin
      ovf_d = (mac_protect[3:0] != {4{mac_result[15]}})
            | (mac_protect[7:4] != {4{mac_result[31]}});
    end else begin
      ovf_d = (mac_protect != {8{mac_result[31]}});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (capture) begin
      ovf_q <= ovf_d;
    end
  end

  assign res_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed job vectors for mac_seq, which drives a
// behavioural 16x16 / dual 8x8 mac with a 2-deep result queue.
module tb_mac_seq;
  import mac_seq_pkg::*;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_sat;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_multiplier;
  logic [15:0]      op_multiplicand;
  logic [2:0]       mac_instruction;
  logic [15:0]      mac_multiplier;
  logic [15:0]      mac_multiplicand;
  logic             mac_stall;
  logic [7:0]       mac_protect;
  logic [31:0]      mac_result;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [7:0]       res_protect;
  logic             busy;
`ifdef MAC_SEQ_OVF_FLAG_EN
  logic             res_ovf;
`endif

  always #5 clk = ~clk;

  mac_seq #(.LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_mode         (cmd_mode),
    .cmd_len          (cmd_len),
    .cmd_sat          (cmd_sat),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_multiplier    (op_multiplier),
    .op_multiplicand  (op_multiplicand),
    .mac_instruction  (mac_instruction),
    .mac_multiplier   (mac_multiplier),
    .mac_multiplicand (mac_multiplicand),
    .mac_stall        (mac_stall),
    .mac_protect      (mac_protect),
    .mac_result       (mac_result),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_protect      (res_protect),
`ifdef MAC_SEQ_OVF_FLAG_EN
    .res_ovf          (res_ovf),
`endif
    .busy             (busy)
  );

  // Accumulator layout {protect, result}; lanes are {p[3:0],r[15:0]}
  // and {p[7:4],r[31:16]} in dual 8x8 mode.
  function automatic logic signed [19:0] lane_step(
    input logic signed [19:0] acc,
    input logic signed [19:0] p,
    input logic [1:0]         op
  );
    logic signed [19:0] mx, mn;
    mx = 20'sh07FFF;
    mn = 20'shF8000;
    case (op)
      2'b00:   return '0;
      2'b01:   return p;
      2'b10:   return acc + p;
      default: return (acc > mx) ? mx : (acc < mn) ? mn : acc;
    endcase
  endfunction

  function automatic logic [39:0] mac_step(
    input logic [39:0] acc,
    input logic [2:0]  ins,
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic signed [39:0] s, p, mx, mn;
    logic signed [19:0] l0, l1, p0, p1;
    mx = 40'sh007FFFFFFF;
    mn = 40'shFF80000000;
    if (!ins[2]) begin
      p = $signed(a) * $signed(b);
      case (ins[1:0])
        2'b00:   s = '0;
        2'b01:   s = p;
        2'b10:   s = $signed(acc) + p;
        default: s = ($signed(acc) > mx) ? mx :
                     ($signed(acc) < mn) ? mn : $signed(acc);
      endcase
      return s;
    end
    l0 = $signed({acc[35:32], acc[15:0]});
    l1 = $signed({acc[39:36], acc[31:16]});
    p0 = $signed(a[7:0]) * $signed(b[7:0]);
    p1 = $signed(a[15:8]) * $signed(b[15:8]);
    l0 = lane_step(l0, p0, ins[1:0]);
    l1 = lane_step(l1, p1, ins[1:0]);
    return {l1[19:16], l0[19:16], l1[15:0], l0[15:0]};
  endfunction

  logic [39:0] acc_m;
  logic [39:0] pipe_m [MAC_PIPE_DEPTH];

  assign mac_result  = pipe_m[MAC_PIPE_DEPTH-1][31:0];
  assign mac_protect = pipe_m[MAC_PIPE_DEPTH-1][39:32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_m <= '0;
      for (int i = 0; i < MAC_PIPE_DEPTH; i++) pipe_m[i] <= '0;
    end else if (!mac_stall) begin
      acc_m     <= mac_step(acc_m, mac_instruction,
                            mac_multiplier, mac_multiplicand);
      pipe_m[0] <= acc_m;
      for (int i = 1; i < MAC_PIPE_DEPTH; i++) pipe_m[i] <= pipe_m[i-1];
    end
  end

  typedef struct {
    logic             mode;
    logic [7:0]       len;
    logic             sat;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [31:0]      exp_d;
    logic [7:0]       exp_p;
  } vec_t;

  function automatic vec_t mk(
    input logic m, input int n, input logic s,
    input logic [15:0] a0, input logic [15:0] b0,
    input logic [15:0] a1, input logic [15:0] b1,
    input logic [15:0] a2, input logic [15:0] b2,
    input logic [31:0] d, input logic [7:0] p
  );
    vec_t v;
    v.mode  = m;
    v.len   = 8'(n);
    v.sat   = s;
    v.a[0]  = a0;
    v.b[0]  = b0;
    v.a[1]  = a1;
    v.b[1]  = b1;
    v.a[2]  = a2;
    v.b[2]  = b2;
    v.exp_d = d;
    v.exp_p = p;
    return v;
  endfunction

  int         checks;
  int         failures;
  logic [2:0] trace[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic run_job(
    input vec_t v, input int gap_at, input int gap_n,
    input int hold, input string tag,
    output logic [31:0] d, output logic [7:0] p, output int lat
  );
    int  idx, gapc, gap_bad, hold_bad;
    bit  done, gap_on;
    idx = 0; gapc = 0; gap_bad = 0; hold_bad = 0;
    done = 1'b0; lat = -1; d = '0; p = '0;
    trace.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_mode  = v.mode;
    cmd_len   = v.len;
    cmd_sat   = v.sat;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = '0;
    for (int i = 0; i < 300 && !done; i++) begin
      gap_on          = (idx == gap_at) && (gapc < gap_n);
      op_valid        = (idx < int'(v.len)) && !gap_on;
      op_multiplier   = (idx < 3) ? v.a[idx[1:0]] : 16'h0;
      op_multiplicand = (idx < 3) ? v.b[idx[1:0]] : 16'h0;
      #1;
      if (gap_on) begin
        gapc++;
        if (!(mac_stall && op_ready)) gap_bad++;
      end
      if (!mac_stall) trace.push_back(mac_instruction);
      if (op_ready && op_valid) idx++;
      if (res_valid) begin
        done = 1'b1;
        lat  = i;
        d    = res_data;
        p    = res_protect;
      end else begin
        @(negedge clk);
      end
    end
    op_valid = 1'b0;
    chk({tag, " done"}, 64'(done), 64'd1);
    if (gap_n > 0) begin
      chk({tag, " gap_len"}, 64'(gapc), 64'(gap_n));
      chk({tag, " gap_stall"}, 64'(gap_bad), 64'd0);
    end
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_len   = 8'd5;
      @(negedge clk);
      #1;
      if (!(res_valid && busy && !cmd_ready &&
            res_data === d && res_protect === p)) hold_bad++;
    end
    if (hold > 0) chk({tag, " hold"}, 64'(hold_bad), 64'd0);
    cmd_valid = 1'b0;
    cmd_len   = '0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    chk({tag, " back_idle"},
        {61'd0, res_valid, cmd_ready, busy}, 64'b010);
  endtask

  vec_t        vecs[10];
  vec_t        v;
  logic [31:0] d;
  logic [7:0]  p;
  int          lat, nsat, mbad;
  string       tg;
  logic [2:0]  tr0[6];

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    tr0 = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b000, 3'b000};
    vecs[0] = mk(0, 3, 0, 16'd3, 16'd4, 16'hFFFE, 16'd5,
                 16'd7, 16'd7, 32'h00000033, 8'h00);
    vecs[1] = mk(1, 1, 0, 16'h0302, 16'h05FE, 0, 0, 0, 0,
                 32'h000FFFFC, 8'h0F);
    vecs[2] = mk(0, 3, 1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 16'h7FFF, 16'h7FFF, 32'h7FFFFFFF, 8'h00);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 8'h00);
    vecs[4] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 8'h00);
    vecs[5] = mk(0, 1, 0, 16'h8000, 16'h8000, 0, 0, 0, 0,
                 32'h40000000, 8'h00);
    vecs[6] = mk(0, 3, 1, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF,
                 16'h8000, 16'h7FFF, 32'h80000000, 8'hFF);
    vecs[7] = mk(0, 3, 0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF,
                 16'h8000, 16'h7FFF, 32'h40018000, 8'hFF);
    vecs[8] = mk(1, 2, 1, 16'h0380, 16'h0280, 16'h0380, 16'h0280,
                 0, 0, 32'h000C7FFF, 8'h00);
    vecs[9] = mk(1, 2, 0, 16'h0380, 16'h0280, 16'h0380, 16'h0280,
                 0, 0, 32'h000C8000, 8'h00);

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len = '0; cmd_sat = 1'b0;
    op_valid = 1'b0; op_multiplier = '0; op_multiplicand = '0;
    res_ready = 1'b0;
    #12;
    chk("reset mac_stall", 64'(mac_stall), 64'd1);
    chk("reset mac_instruction", 64'(mac_instruction), 64'd0);
    chk("reset res_valid", 64'(res_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset op_ready", 64'(op_ready), 64'd0);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset res_data", 64'(res_data), 64'd0);
    reset_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      v  = vecs[k];
      tg = $sformatf("v%0d", k);
      run_job(v, -1, 0, 0, tg, d, p, lat);
      nsat = 0;
      mbad = 0;
      foreach (trace[j]) begin
        if (trace[j][1:0] == 2'b11) nsat++;
        if (trace[j][2] != v.mode) mbad++;
      end
      chk({tg, " res_data"}, 64'(d), 64'(v.exp_d));
      chk({tg, " res_protect"}, 64'(p), 64'(v.exp_p));
      chk({tg, " latency"}, 64'(lat), 64'(4 + int'(v.len) + int'(v.sat)));
      chk({tg, " issues"}, 64'(trace.size()),
          64'(3 + int'(v.len) + int'(v.sat)));
      chk({tg, " sat_ops"}, 64'(nsat), 64'(v.sat));
      chk({tg, " mode_bit"}, 64'(mbad), 64'd0);
      if (k == 0 || k == 2) begin
        chk({tg, " pre_drain_op"}, 64'(trace[trace.size()-3]),
            (k == 2) ? 64'b011 : 64'b010);
      end
    end

    run_job(vecs[0], -1, 0, 0, "trace", d, p, lat);
    chk("trace len", 64'(trace.size()), 64'd6);
    for (int j = 0; j < 6 && j < trace.size(); j++)
      chk($sformatf("trace op%0d", j), 64'(trace[j]), 64'(tr0[j]));

    run_job(vecs[0], 1, 4, 0, "gap", d, p, lat);
    chk("gap res_data", 64'(d), 64'h33);
    chk("gap latency", 64'(lat), 64'd11);
    chk("gap issues", 64'(trace.size()), 64'd6);

    run_job(vecs[2], -1, 0, 5, "hold", d, p, lat);
    chk("hold res_data", 64'(d), 64'h7FFFFFFF);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_len = 8'd3; cmd_sat = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_multiplier = 16'h1234; op_multiplicand = 16'h5678;
    @(negedge clk);
    #2;
    chk("midjob op_ready", 64'(op_ready), 64'd1);
    chk("midjob issue", 64'(mac_stall), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("async mac_stall", 64'(mac_stall), 64'd1);
    chk("async mac_instruction", 64'(mac_instruction), 64'd0);
    chk("async mac_operands", {32'd0, mac_multiplier, mac_multiplicand}, 64'd0);
    chk("async res_valid", 64'(res_valid), 64'd0);
    chk("async res_data", 64'(res_data), 64'd0);
    chk("async res_protect", 64'(res_protect), 64'd0);
    chk("async op_ready", 64'(op_ready), 64'd0);
    chk("async busy", 64'(busy), 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    v = mk(0, 1, 0, 16'd2, 16'd3, 0, 0, 0, 0, 32'd6, 8'h00);
    run_job(v, -1, 0, 0, "post_rst", d, p, lat);
    chk("post_rst res_data", 64'(d), 64'd6);
    chk("post_rst res_protect", 64'(p), 64'd0);
    chk("post_rst latency", 64'(lat), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
